tmr_scrub_regfile: RTL and testbench
====================================

TMR_SCRUB_REGFILE -- requirements
Module: tmr_scrub_regfile

Interface
REQ-001 SHALL have parameter WIDTH, 8, data bits per entry.
REQ-002 SHALL have parameter DEPTH, 4, number of entries (power of 2, >=2); AW = log2(DEPTH).
REQ-003 SHALL have parameter SCRUB_PERIOD, 16, idle cycles between scrub passes (>=2).
REQ-004 SHALL have parameter CNT_WIDTH, 8, error counter width.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have ports wr_en/wr_addr/wr_data  input  1/AW/WIDTH  write all three copies.
REQ-008 SHALL have ports rd_en/rd_addr  input  1/AW  read request.
REQ-009 SHALL have ports rd_data/rd_valid/rd_err  output  WIDTH/1/1  voted read data, valid strobe, mismatch flag.
REQ-010 SHALL have ports inj_en/inj_copy/inj_addr/inj_mask  input  1/2/AW/WIDTH  fault injection into copy 0=A, 1=B, 2=C.
REQ-011 SHALL have ports err_clear  input  1  and err_count  output  CNT_WIDTH  saturating mismatch counter.
REQ-012 SHALL have port scrub_busy  output  1  high while a scrub pass is in progress.

Function
REQ-013 SHALL hold three storage copies A/B/C of DEPTH x WIDTH bits.
REQ-014 wr_en SHALL write wr_data to entry wr_addr of all three copies at the next edge.
REQ-015 rd_en SHALL register the bitwise majority of A/B/C[rd_addr] into rd_data with rd_valid=1 one cycle later; rd_valid=0 otherwise; rd_data holds its value when rd_valid=0.
REQ-016 rd_err SHALL be 1 with rd_valid when any bit of the three copies disagrees; otherwise 0.
REQ-017 A read and a write to the same address in the same cycle SHALL return the pre-write (old) voted value.
REQ-018 inj_en SHALL XOR inj_mask into copy inj_copy at inj_addr; inj_copy=3 SHALL be ignored; if wr_en targets the same address in the same cycle, the stored value SHALL be wr_data XOR inj_mask in the selected copy only.
REQ-019 Scrubber FSM SHALL have states IDLE, WAIT, SCRUB; IDLE->WAIT after reset; WAIT counts SCRUB_PERIOD cycles then ->SCRUB; SCRUB visits addresses 0..DEPTH-1, one per cycle, then ->WAIT with timer restarted.
REQ-020 In SCRUB, the voted value of the current entry SHALL be written back to all three copies, unless wr_en targets the same address that cycle (write wins); the pointer SHALL advance in either case.
REQ-021 scrub_busy SHALL be 1 exactly in SCRUB state.
REQ-022 err_count SHALL increment by one for each mismatch event per cycle (read with rd_err, scrub entry with mismatch; 0..2 per cycle).
REQ-023 err_count SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-024 err_clear SHALL zero err_count at the next edge and take priority over same-cycle increments.
REQ-025 Two copies flipped in the same bit SHALL yield the wrong voted value; only rd_err/err_count report it; no correction is guaranteed.

Reset
REQ-026 While rstn=0 at an edge: all copies 0, rd_data 0, rd_valid 0, rd_err 0, err_count 0, FSM IDLE, timer and pointer 0.
REQ-027 Reset asserted mid-scrub SHALL abort the pass; no partial write-back SHALL occur in the reset cycle.

Configuration
REQ-028 Macro TMR_SCRUB_EN defined: scrubber FSM per REQ-019..021 present.
REQ-029 Macro TMR_SCRUB_EN undefined: no FSM, scrub_busy tied 0, copies change only by write/injection; scrub-related counter events absent.

Verification
REQ-030 Reset, write 0xA5 to addr 2, read addr 2 -> next cycle rd_data=0xA5, rd_valid=1, rd_err=0, err_count=0.
REQ-031 Write 0x0F addr 1, inject mask 0x01 copy B addr 1, read -> rd_data=0x0F, rd_err=1, err_count=1.
REQ-032 With TMR_SCRUB_EN, inject mask 0x80 copy C addr 3, wait one full scrub pass, read -> rd_err=0, err_count=1 (from scrub).
REQ-033 Inject mask 0x03 into copies A and B addr 0 (data 0x00), read -> rd_data=0x03, rd_err=1.
REQ-034 CNT_WIDTH=2, force 5 mismatching reads -> err_count stays 3; assert err_clear with a mismatching read same cycle -> err_count=0.
REQ-035 Assert rstn=0 while scrub_busy=1 -> next cycle scrub_busy=0, err_count=0, all entries read 0x00.

Source files
------------

// File: rtl/tmr_scrub_regfile.sv
// Triple-redundant register file: majority-voted reads one cycle after rd_en, fault injection, saturating error counter;
// defining TMR_SCRUB_EN adds a background scrubber that rewrites voted values; no backpressure, writes always win over scrub.
module tmr_scrub_regfile #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int SCRUB_PERIOD = 16,
    parameter int CNT_WIDTH    = 8,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    output logic                 rd_err,
    input  logic                 inj_en,
    input  logic [1:0]           inj_copy,
    input  logic [AW-1:0]        inj_addr,
    input  logic [WIDTH-1:0]     inj_mask,
    input  logic                 err_clear,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 scrub_busy
);
    localparam logic [CNT_WIDTH+1:0] CNT_SAT = {2'b00, {CNT_WIDTH{1'b1}}};

    logic [WIDTH-1:0] mem     [3][DEPTH];
    logic [WIDTH-1:0] memNext [3][DEPTH];

    logic [WIDTH-1:0] rdA, rdB, rdC, rdVote;
    logic             rdMis;
    logic             scrubActive;
    logic [AW-1:0]    scrubPtr;
    logic [WIDTH-1:0] scA, scB, scC, scVote;
    logic             scMis;

    assign rdA    = mem[0][rd_addr];
    assign rdB    = mem[1][rd_addr];
    assign rdC    = mem[2][rd_addr];
    assign rdVote = (rdA & rdB) | (rdA & rdC) | (rdB & rdC);
    assign rdMis  = (rdA != rdB) || (rdA != rdC);

    assign scA    = mem[0][scrubPtr];
    assign scB    = mem[1][scrubPtr];
    assign scC    = mem[2][scrubPtr];
    assign scVote = (scA & scB) | (scA & scC) | (scB & scC);
    assign scMis  = (scA != scB) || (scA != scC);

`ifdef TMR_SCRUB_EN
    typedef enum logic [1:0] {IDLE, WAIT, SCRUB} scrubState_t;
    localparam int TW = $clog2(SCRUB_PERIOD);

    scrubState_t   state;
    logic [TW-1:0] timer;
    logic          scrubBusyQ;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            timer      <= '0;
            scrubPtr   <= '0;
            scrubBusyQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= WAIT;
                    timer <= '0;
                end
                WAIT: begin
                    if (timer == TW'(SCRUB_PERIOD - 1)) begin
                        state      <= SCRUB;
                        timer      <= '0;
                        scrubPtr   <= '0;
                        scrubBusyQ <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SCRUB: begin
                    // Pointer wraps to 0 on the last entry since DEPTH is a power of two
                    scrubPtr <= scrubPtr + AW'(1);
                    if (scrubPtr == AW'(DEPTH - 1)) begin
                        state      <= WAIT;
                        timer      <= '0;
                        scrubBusyQ <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    scrubBusyQ <= 1'b0;
                end
            endcase
        end
    end

    assign scrubActive = (state == SCRUB);
    assign scrub_busy  = scrubBusyQ;
`else
    assign scrubActive = 1'b0;
    assign scrubPtr    = '0;
    assign scrub_busy  = 1'b0;
`endif

    // Precedence per entry: scrub write-back, then host write, then injection XOR on top
    always_comb begin
        memNext = mem;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (scrubActive && scrubPtr == AW'(i))
                    memNext[c][i] = scVote;
                if (wr_en && wr_addr == AW'(i))
                    memNext[c][i] = wr_data;
                if (inj_en && inj_copy == 2'(c) && inj_addr == AW'(i))
                    memNext[c][i] = memNext[c][i] ^ inj_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int c = 0; c < 3; c++)
                for (int i = 0; i < DEPTH; i++)
                    mem[c][i] <= '0;
        end else begin
            mem <= memNext;
        end
    end

    logic [1:0]           errEvents;
    logic [CNT_WIDTH+1:0] cntSum;

    assign errEvents = 2'(rd_en & rdMis) + 2'(scrubActive & scMis);
    assign cntSum    = {2'b00, err_count} + {CNT_WIDTH'(0), errEvents};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
            err_count <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en & rdMis;
            if (rd_en)
                rd_data <= rdVote;
            if (err_clear)
                err_count <= '0;
            else if (cntSum > CNT_SAT)
                err_count <= '1;
            else
                err_count <= cntSum[CNT_WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_tmr_scrub_regfile.sv
// Randomised bench for tmr_scrub_regfile against a bit-counting reference model; a second instance checks 2-bit counter saturation.
`timescale 1ns/1ps
module tb_tmr_scrub_regfile;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int PER   = 16;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rstn, wr_en, rd_en, inj_en, err_clear;
    logic [AW-1:0]    wr_addr, rd_addr, inj_addr;
    logic [WIDTH-1:0] wr_data, inj_mask;
    logic [1:0]       inj_copy;
    logic [WIDTH-1:0] rd_data, rd_data2;
    logic             rd_valid, rd_err, scrub_busy, rd_valid2, rd_err2, scrub_busy2;
    logic [7:0]       err_count;
    logic [1:0]       err_count2;

    always #5 clk = ~clk;

    tmr_scrub_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SCRUB_PERIOD(PER), .CNT_WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
        .inj_en(inj_en), .inj_copy(inj_copy), .inj_addr(inj_addr), .inj_mask(inj_mask),
        .err_clear(err_clear), .err_count(err_count), .scrub_busy(scrub_busy));

    tmr_scrub_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SCRUB_PERIOD(PER), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_err(rd_err2),
        .inj_en(inj_en), .inj_copy(inj_copy), .inj_addr(inj_addr), .inj_mask(inj_mask),
        .err_clear(err_clear), .err_count(err_count2), .scrub_busy(scrub_busy2));

    int vecCount  = 0;
    int missCount = 0;

    logic [WIDTH-1:0] mMem [3][DEPTH];
    logic [WIDTH-1:0] eRdData;
    logic             eRdValid, eRdErr;
    int               eCnt, eCnt2, tCyc;

    function automatic logic [WIDTH-1:0] vote3(input logic [WIDTH-1:0] a, b, c);
        logic [WIDTH-1:0] v;
        for (int k = 0; k < WIDTH; k++) begin
            int n;
            n = int'(a[k]) + int'(b[k]) + int'(c[k]);
            v[k] = (n >= 2);
        end
        return v;
    endfunction

    function automatic logic differ3(input logic [WIDTH-1:0] a, b, c);
        return !(a == b && b == c);
    endfunction

    // Scrub schedule from reset: one IDLE cycle, then repeating PER waiting cycles followed by DEPTH scrub cycles
    function automatic int scrubIdxAt(input int t);
`ifdef TMR_SCRUB_EN
        int ph;
        if (t < 1) return -1;
        ph = (t - 1) % (PER + DEPTH);
        return (ph >= PER) ? ph - PER : -1;
`else
        return (t < 0) ? 0 : -1;
`endif
    endfunction

    function automatic int satAdd(input int a, input int b, input int mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    task automatic idleIn();
        wr_en = 0; rd_en = 0; inj_en = 0; err_clear = 0;
        wr_addr = '0; rd_addr = '0; inj_addr = '0; wr_data = '0; inj_mask = '0; inj_copy = 2'd0;
    endtask

    // Advance the model with the current inputs, then clock the DUT and settle
    task automatic tick();
        int ev, s;
        logic [WIDTH-1:0] v;
        if (!rstn) begin
            for (int c = 0; c < 3; c++)
                for (int i = 0; i < DEPTH; i++) mMem[c][i] = '0;
            eRdData = '0; eRdValid = 0; eRdErr = 0; eCnt = 0; eCnt2 = 0; tCyc = 0;
        end else begin
            ev = 0;
            eRdValid = rd_en;
            eRdErr = 0;
            if (rd_en) begin
                eRdData = vote3(mMem[0][rd_addr], mMem[1][rd_addr], mMem[2][rd_addr]);
                eRdErr  = differ3(mMem[0][rd_addr], mMem[1][rd_addr], mMem[2][rd_addr]);
                ev += int'(eRdErr);
            end
            s = scrubIdxAt(tCyc);
            if (s >= 0) begin
                v = vote3(mMem[0][s], mMem[1][s], mMem[2][s]);
                if (differ3(mMem[0][s], mMem[1][s], mMem[2][s])) ev++;
                for (int c = 0; c < 3; c++) mMem[c][s] = v;
            end
            if (wr_en)
                for (int c = 0; c < 3; c++) mMem[c][wr_addr] = wr_data;
            if (inj_en && inj_copy != 2'd3)
                mMem[inj_copy][inj_addr] = mMem[inj_copy][inj_addr] ^ inj_mask;
            if (err_clear) begin
                eCnt = 0; eCnt2 = 0;
            end else begin
                eCnt  = satAdd(eCnt, ev, 255);
                eCnt2 = satAdd(eCnt2, ev, 3);
            end
            tCyc++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic expBusy();
        return scrubIdxAt(tCyc) >= 0;
    endfunction

    task automatic test_reset();
        rstn = 0; idleIn();
        tick(); tick();
        vecCount++; if (rd_valid !== 1'b0) begin missCount++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        vecCount++; if (rd_err !== 1'b0) begin missCount++; $display("FAIL reset_rd_err got %b want 0", rd_err); end
        vecCount++; if (rd_data !== 8'h00) begin missCount++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        vecCount++; if (err_count !== 8'h00) begin missCount++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        vecCount++; if (scrub_busy !== 1'b0) begin missCount++; $display("FAIL reset_scrub_busy got %b want 0", scrub_busy); end
        rstn = 1;
    endtask

    task automatic test_basic();
        wr_en = 1; wr_addr = 2; wr_data = 8'hA5; tick(); idleIn();
        rd_en = 1; rd_addr = 2; tick(); idleIn();
        vecCount++; if (rd_data !== 8'hA5 || eRdData !== 8'hA5) begin missCount++; $display("FAIL basic_rd_data got %h want a5 (model %h)", rd_data, eRdData); end
        vecCount++; if (rd_valid !== 1'b1) begin missCount++; $display("FAIL basic_rd_valid got %b want 1", rd_valid); end
        vecCount++; if (rd_err !== eRdErr) begin missCount++; $display("FAIL basic_rd_err got %b want %b", rd_err, eRdErr); end
        vecCount++; if (err_count !== 8'(eCnt)) begin missCount++; $display("FAIL basic_err_count got %0d want %0d", err_count, eCnt); end
        tick();
        vecCount++; if (rd_valid !== 1'b0 || rd_data !== eRdData) begin missCount++; $display("FAIL basic_hold got v=%b d=%h want v=0 d=%h", rd_valid, rd_data, eRdData); end
    endtask

    task automatic test_inject();
        wr_en = 1; wr_addr = 1; wr_data = 8'h0F; tick(); idleIn();
        inj_en = 1; inj_copy = 1; inj_addr = 1; inj_mask = 8'h01; tick(); idleIn();
        rd_en = 1; rd_addr = 1; tick(); idleIn();
        vecCount++; if (rd_data !== eRdData) begin missCount++; $display("FAIL single_flip_data got %h want %h", rd_data, eRdData); end
        vecCount++; if (rd_err !== eRdErr) begin missCount++; $display("FAIL single_flip_err got %b want %b", rd_err, eRdErr); end
        vecCount++; if (err_count !== 8'(eCnt)) begin missCount++; $display("FAIL single_flip_count got %0d want %0d", err_count, eCnt); end
        wr_en = 1; wr_addr = 0; wr_data = 8'h00; tick(); idleIn();
        inj_en = 1; inj_copy = 0; inj_addr = 0; inj_mask = 8'h03; tick();
        inj_copy = 1; tick(); idleIn();
        rd_en = 1; rd_addr = 0; tick(); idleIn();
        vecCount++; if (rd_data !== eRdData) begin missCount++; $display("FAIL double_flip_data got %h want %h", rd_data, eRdData); end
        vecCount++; if (rd_err !== eRdErr) begin missCount++; $display("FAIL double_flip_err got %b want %b", rd_err, eRdErr); end
        inj_en = 1; inj_copy = 3; inj_addr = 2; inj_mask = 8'hFF; tick(); idleIn();
        rd_en = 1; rd_addr = 2; tick(); idleIn();
        vecCount++; if (rd_data !== eRdData || rd_err !== eRdErr) begin missCount++; $display("FAIL copy3_ignored got %h/%b want %h/%b", rd_data, rd_err, eRdData, eRdErr); end
    endtask

    task automatic test_same_cycle();
        wr_en = 1; wr_addr = 3; wr_data = 8'h11; tick(); idleIn();
        rd_en = 1; rd_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 8'h22; tick(); idleIn();
        vecCount++; if (rd_data !== eRdData) begin missCount++; $display("FAIL rd_wr_old got %h want %h", rd_data, eRdData); end
        rd_en = 1; rd_addr = 3; tick(); idleIn();
        vecCount++; if (rd_data !== eRdData) begin missCount++; $display("FAIL rd_after_wr got %h want %h", rd_data, eRdData); end
        wr_en = 1; wr_addr = 3; wr_data = 8'h40; inj_en = 1; inj_copy = 2; inj_addr = 3; inj_mask = 8'h0F; tick(); idleIn();
        rd_en = 1; rd_addr = 3; tick(); idleIn();
        vecCount++; if (rd_data !== eRdData || rd_err !== eRdErr) begin missCount++; $display("FAIL wr_inj_same got %h/%b want %h/%b", rd_data, rd_err, eRdData, eRdErr); end
    endtask

    task automatic test_scrub();
        rstn = 0; idleIn(); tick(); rstn = 1;
        inj_en = 1; inj_copy = 2; inj_addr = 3; inj_mask = 8'h80; tick(); idleIn();
        for (int n = 0; n < PER + DEPTH + 2; n++) begin
            tick();
            vecCount++; if (scrub_busy !== expBusy()) begin missCount++; $display("FAIL scrub_busy cyc %0d got %b want %b", tCyc, scrub_busy, expBusy()); end
        end
        rd_en = 1; rd_addr = 3; tick(); idleIn();
        vecCount++; if (rd_err !== eRdErr || rd_data !== eRdData) begin missCount++; $display("FAIL scrub_repair got %h/%b want %h/%b", rd_data, rd_err, eRdData, eRdErr); end
        vecCount++; if (err_count !== 8'(eCnt)) begin missCount++; $display("FAIL scrub_count got %0d want %0d", err_count, eCnt); end
    endtask

    // Keep addr 0 faulty by re-injecting whenever the model says the copies agree
    task automatic test_saturation();
        rstn = 0; idleIn(); tick(); rstn = 1;
        for (int n = 0; n < 300; n++) begin
            idleIn();
            rd_en = 1; rd_addr = 0;
            inj_en = !differ3(mMem[0][0], mMem[1][0], mMem[2][0]); inj_copy = 0; inj_addr = 0; inj_mask = 8'h01;
            tick();
            if (n == 6) begin
                vecCount++; if (err_count2 !== 2'(eCnt2)) begin missCount++; $display("FAIL sat2_early got %0d want %0d", err_count2, eCnt2); end
            end
        end
        vecCount++; if (err_count !== 8'(eCnt)) begin missCount++; $display("FAIL sat8 got %0d want %0d", err_count, eCnt); end
        vecCount++; if (err_count2 !== 2'(eCnt2)) begin missCount++; $display("FAIL sat2 got %0d want %0d", err_count2, eCnt2); end
        idleIn();
        if (!differ3(mMem[0][0], mMem[1][0], mMem[2][0])) begin
            inj_en = 1; inj_copy = 0; inj_addr = 0; inj_mask = 8'h01; tick(); idleIn();
        end
        rd_en = 1; rd_addr = 0; err_clear = 1; tick(); idleIn();
        vecCount++; if (err_count !== 8'(eCnt) || err_count2 !== 2'(eCnt2)) begin missCount++; $display("FAIL clear_prio got %0d/%0d want %0d/%0d", err_count, err_count2, eCnt, eCnt2); end
        vecCount++; if (rd_err !== eRdErr) begin missCount++; $display("FAIL clear_rd_err got %b want %b", rd_err, eRdErr); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en = ($urandom_range(9) < 3); wr_addr = AW'($urandom_range(DEPTH - 1)); wr_data = 8'($urandom);
            rd_en = ($urandom_range(1) == 1); rd_addr = AW'($urandom_range(DEPTH - 1));
            inj_en = ($urandom_range(9) < 2); inj_copy = 2'($urandom_range(3));
            inj_addr = AW'($urandom_range(DEPTH - 1)); inj_mask = 8'($urandom);
            err_clear = ($urandom_range(31) == 0);
            tick();
            vecCount++; if (rd_valid !== eRdValid) begin missCount++; $display("FAIL rnd_valid cyc %0d got %b want %b", n, rd_valid, eRdValid); end
            vecCount++; if (rd_data !== eRdData) begin missCount++; $display("FAIL rnd_data cyc %0d got %h want %h", n, rd_data, eRdData); end
            vecCount++; if (rd_err !== eRdErr) begin missCount++; $display("FAIL rnd_err cyc %0d got %b want %b", n, rd_err, eRdErr); end
            vecCount++; if (err_count !== 8'(eCnt) || err_count2 !== 2'(eCnt2)) begin missCount++; $display("FAIL rnd_count cyc %0d got %0d/%0d want %0d/%0d", n, err_count, err_count2, eCnt, eCnt2); end
            vecCount++; if (scrub_busy !== expBusy()) begin missCount++; $display("FAIL rnd_busy cyc %0d got %b want %b", n, scrub_busy, expBusy()); end
        end
        idleIn();
    endtask

    task automatic test_reset_midscrub();
`ifdef TMR_SCRUB_EN
        int n = 0;
        while (scrub_busy !== 1'b1 && n < 64) begin tick(); n++; end
        vecCount++; if (scrub_busy !== 1'b1) begin missCount++; $display("FAIL midscrub_wait timeout got busy=%b want 1", scrub_busy); end
`endif
        rstn = 0; tick();
        vecCount++; if (scrub_busy !== 1'b0) begin missCount++; $display("FAIL midscrub_busy got %b want 0", scrub_busy); end
        vecCount++; if (err_count !== 8'h00) begin missCount++; $display("FAIL midscrub_count got %0d want 0", err_count); end
        rstn = 1;
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 1; rd_addr = AW'(a); tick();
            vecCount++; if (rd_data !== 8'h00 || rd_err !== 1'b0) begin missCount++; $display("FAIL midscrub_entry %0d got %h/%b want 00/0", a, rd_data, rd_err); end
        end
        idleIn();
    endtask

    initial begin
        idleIn();
        rstn = 0;
        test_reset();
        test_basic();
        test_inject();
        test_same_cycle();
        test_scrub();
        test_saturation();
        test_random();
        test_reset_midscrub();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
